// File: rtl/step_mode_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : step_mode_counter_pkg
//  Description : Shared types and constants for the step-mode counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package step_mode_counter_pkg;

    // Step rule applied on each count tick
    typedef enum logic [1:0] {
        MODE_EVEN = 2'd0,
        MODE_ODD  = 2'd1,
        MODE_BIN  = 2'd2,
        MODE_STEP = 2'd3
    } mode_t;

    // Even/odd modes move by two so that parity is preserved
    localparam int c_PARITY_STEP = 2;

endpackage : step_mode_counter_pkg
`default_nettype wire

// File: rtl/step_mode_counter_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides clk by DIV; tick_en is high for the single enabled
//                cycle in which the counter sits at DIV-1 (the terminal
//                value), so the caller updates on that same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sync_clr,
    output logic tick_en
);

    // Counter must hold 0..DIV-1; DIV=1 still gets a one-bit register that stays 0
    localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_last;

    assign w_last = (r_cnt == c_LAST);

    // Terminal value is suppressed by en=0 and overridden by a synchronous clear
    assign tick_en = en & w_last & ~sync_clr;

    // Prescaler count: clear wins, otherwise advance only while enabled
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/step_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : step_mode_counter
//  Description : Prescaled up/down counter with even, odd, binary and
//                custom-step rules, synchronous load, tick and wrap pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_mode_counter
    import step_mode_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap
);

    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_wrap;

    logic             w_tick_en;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_delta;
    logic [WIDTH:0]   w_sum;

    // A load restarts the prescaler so the next tick lands DIV cycles later
    tick_prescaler #(
        .DIV      (DIV)
    ) u_prescaler (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .sync_clr (load),
        .tick_en  (w_tick_en)
    );

    // Operand selection; parity modes first force the LSB so a mismatch is
    // corrected on the first tick after a mode change
    always_comb begin
        w_base  = r_q;
        w_delta = WIDTH'(1);
        case (mode_t'(mode))
            MODE_EVEN: begin
                w_base  = {r_q[WIDTH-1:1], 1'b0};
                w_delta = WIDTH'(c_PARITY_STEP);
            end
            MODE_ODD: begin
                w_base  = {r_q[WIDTH-1:1], 1'b1};
                w_delta = WIDTH'(c_PARITY_STEP);
            end
            MODE_BIN: begin
                w_delta = WIDTH'(1);
            end
            MODE_STEP: begin
                w_delta = step;
            end
            default: begin
                w_delta = WIDTH'(1);
            end
        endcase
    end

    // One extra bit carries the carry-out (up) or borrow-out (down)
    always_comb begin
        if (dir) begin
            w_sum = {1'b0, w_base} - {1'b0, w_delta};
        end else begin
            w_sum = {1'b0, w_base} + {1'b0, w_delta};
        end
    end

    // Count register with load priority over a coincident tick
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q    <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= load_val;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_tick_en) begin
            r_q    <= w_sum[WIDTH-1:0];
            r_tick <= 1'b1;
            r_wrap <= w_sum[WIDTH];
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign q    = r_q;
    assign tick = r_tick;
    assign wrap = r_wrap;

endmodule : step_mode_counter
`default_nettype wire

// File: tb/tb_step_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_mode_counter
//  Description : Self-checking bench; three counters (DIV = 3, 1, 4) share
//                one stimulus set and are compared each cycle against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_mode_counter;

    localparam int c_W = 4;
    localparam int c_N = 3;

    logic             clk = 1'b0;
    logic             clr;
    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic [c_W-1:0]   step;
    logic             load;
    logic [c_W-1:0]   load_val;

    logic [c_W-1:0]   w_q [c_N];
    logic [c_N-1:0]   w_tick;
    logic [c_N-1:0]   w_wrap;

    int m_q   [c_N];
    int m_pre [c_N];
    int m_tick[c_N];
    int m_wrap[c_N];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    step_mode_counter #(.WIDTH(c_W), .DIV(3)) u_dut0 (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .dir(dir), .step(step),
        .load(load), .load_val(load_val), .q(w_q[0]), .tick(w_tick[0]), .wrap(w_wrap[0]));

    step_mode_counter #(.WIDTH(c_W), .DIV(1)) u_dut1 (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .dir(dir), .step(step),
        .load(load), .load_val(load_val), .q(w_q[1]), .tick(w_tick[1]), .wrap(w_wrap[1]));

    step_mode_counter #(.WIDTH(c_W), .DIV(4)) u_dut2 (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .dir(dir), .step(step),
        .load(load), .load_val(load_val), .q(w_q[2]), .tick(w_tick[2]), .wrap(w_wrap[2]));

    function automatic int div_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    // Compare every instance against the model
    task automatic compare_all(input string tag);
        for (int k = 0; k < c_N; k++) begin
            n_vec++;
            if (int'(w_q[k]) !== m_q[k]) begin
                n_err++;
                $display("FAIL %s q inst%0d: got %0d expected %0d", tag, k, w_q[k], m_q[k]);
            end
            n_vec++;
            if (int'(w_tick[k]) !== m_tick[k]) begin
                n_err++;
                $display("FAIL %s tick inst%0d: got %0d expected %0d", tag, k, w_tick[k], m_tick[k]);
            end
            n_vec++;
            if (int'(w_wrap[k]) !== m_wrap[k]) begin
                n_err++;
                $display("FAIL %s wrap inst%0d: got %0d expected %0d", tag, k, w_wrap[k], m_wrap[k]);
            end
        end
    endtask

    // Advance the model by one clock from the current inputs, then clock the DUTs
    task automatic cycle(input string tag);
        int base, d, r;
        for (int k = 0; k < c_N; k++) begin
            if (load) begin
                m_q[k] = int'(load_val); m_pre[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
            end else if (en && m_pre[k] == div_of(k) - 1) begin
                base = m_q[k];
                case (mode)
                    2'd0:    begin base = (base / 2) * 2;     d = 2; end
                    2'd1:    begin base = (base / 2) * 2 + 1; d = 2; end
                    2'd2:    d = 1;
                    default: d = int'(step);
                endcase
                r = dir ? base - d : base + d;
                m_wrap[k] = (r < 0 || r > 15) ? 1 : 0;
                m_q[k]    = (r + 16) % 16;
                m_tick[k] = 1;
                m_pre[k]  = 0;
            end else begin
                if (en) m_pre[k] = m_pre[k] + 1;
                m_tick[k] = 0; m_wrap[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous clear pulse placed between clock edges
    task automatic pulse_clr(input string tag);
        clr = 1'b1;
        #1;
        for (int k = 0; k < c_N; k++) begin
            m_q[k] = 0; m_pre[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
        end
        compare_all(tag);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b0; mode = 2'd0; dir = 1'b0; step = '0; load = 1'b0; load_val = '0;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < c_N; k++) begin
            m_q[k] = 0; m_pre[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
        end
        compare_all("reset");
        clr = 1'b0;
    endtask

    // Even, up, DIV=3: q = 2,4,..,14,0 on cycles 3,6,..,24; wrap only on 14->0
    task automatic test_even_up();
        pulse_clr("even_clr");
        en = 1'b1; mode = 2'd0; dir = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            cycle("even_up");
            n_vec++;
            if (c % 3 == 0 && int'(w_q[0]) !== (2 * (c / 3)) % 16) begin
                n_err++;
                $display("FAIL even_seq cycle%0d: got %0d expected %0d", c, w_q[0], (2 * (c / 3)) % 16);
            end
        end
        n_vec++;
        if (w_wrap[0] !== 1'b1) begin
            n_err++;
            $display("FAIL even_wrap: got %0b expected 1", w_wrap[0]);
        end
    endtask

    // Odd, down, DIV=1 after loading 1: 15 (wrap), 13, 11
    task automatic test_odd_down();
        mode = 2'd1; dir = 1'b1; en = 1'b1;
        load = 1'b1; load_val = 4'd1;
        cycle("odd_load");
        load = 1'b0;
        cycle("odd_down");
        n_vec++;
        if (w_q[1] !== 4'd15 || w_wrap[1] !== 1'b1) begin
            n_err++;
            $display("FAIL odd_borrow: got q=%0d wrap=%0b expected q=15 wrap=1", w_q[1], w_wrap[1]);
        end
        cycle("odd_down");
        n_vec++;
        if (w_q[1] !== 4'd13) begin
            n_err++;
            $display("FAIL odd_13: got %0d expected 13", w_q[1]);
        end
        cycle("odd_down");
        n_vec++;
        if (w_q[1] !== 4'd11) begin
            n_err++;
            $display("FAIL odd_11: got %0d expected 11", w_q[1]);
        end
    endtask

    // Parity correction: 6 in odd-up becomes 9, then binary gives 10
    task automatic test_mode_switch();
        load = 1'b1; load_val = 4'd6; mode = 2'd0;
        cycle("sw_load");
        load = 1'b0; mode = 2'd1; dir = 1'b0;
        cycle("sw_odd");
        n_vec++;
        if (w_q[1] !== 4'd9) begin
            n_err++;
            $display("FAIL sw_odd: got %0d expected 9", w_q[1]);
        end
        mode = 2'd2;
        cycle("sw_bin");
        n_vec++;
        if (w_q[1] !== 4'd10) begin
            n_err++;
            $display("FAIL sw_bin: got %0d expected 10", w_q[1]);
        end
    endtask

    // Custom step on DIV=4: 13+5 -> 2 with carry; step 0 holds but still ticks
    task automatic test_step();
        load = 1'b1; load_val = 4'd13; mode = 2'd3; step = 4'd5; dir = 1'b0;
        cycle("step_load");
        load = 1'b0;
        repeat (4) cycle("step_run");
        n_vec++;
        if (w_q[2] !== 4'd2 || w_wrap[2] !== 1'b1 || w_tick[2] !== 1'b1) begin
            n_err++;
            $display("FAIL step_carry: got q=%0d wrap=%0b tick=%0b expected q=2 wrap=1 tick=1",
                     w_q[2], w_wrap[2], w_tick[2]);
        end
        step = 4'd0;
        repeat (4) cycle("step_zero");
        n_vec++;
        if (w_q[2] !== 4'd2 || w_tick[2] !== 1'b1) begin
            n_err++;
            $display("FAIL step_hold: got q=%0d tick=%0b expected q=2 tick=1", w_q[2], w_tick[2]);
        end
    endtask

    // Load on the terminal prescaler cycle wins; next tick DIV cycles on
    task automatic test_load_terminal();
        int guard;
        mode = 2'd2; dir = 1'b0; en = 1'b1;
        guard = 0;
        while (m_pre[0] != 2 && guard < 10) begin
            cycle("lt_align");
            guard++;
        end
        n_vec++;
        if (guard >= 10) begin
            n_err++;
            $display("FAIL lt_align: got timeout expected terminal prescaler");
        end
        load = 1'b1; load_val = 4'd5;
        cycle("lt_load");
        n_vec++;
        if (w_q[0] !== 4'd5 || w_tick[0] !== 1'b0) begin
            n_err++;
            $display("FAIL lt_load: got q=%0d tick=%0b expected q=5 tick=0", w_q[0], w_tick[0]);
        end
        load = 1'b0;
        repeat (3) cycle("lt_after");
        n_vec++;
        if (w_tick[0] !== 1'b1 || w_q[0] !== 4'd6) begin
            n_err++;
            $display("FAIL lt_next: got q=%0d tick=%0b expected q=6 tick=1", w_q[0], w_tick[0]);
        end
    endtask

    // Clear mid-period, first tick DIV cycles after release, then freeze
    task automatic test_clr_mid();
        logic [c_W-1:0] held;
        load = 1'b1; load_val = 4'd9;
        cycle("clr_load");
        load = 1'b0; mode = 2'd2; dir = 1'b0; en = 1'b1;
        cycle("clr_mid");
        pulse_clr("clr_pulse");
        n_vec++;
        if (w_q[0] !== 4'd0 || w_tick[0] !== 1'b0 || w_wrap[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_now: got q=%0d tick=%0b wrap=%0b expected 0 0 0", w_q[0], w_tick[0], w_wrap[0]);
        end
        repeat (2) cycle("clr_rel");
        n_vec++;
        if (w_tick[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_early: got tick=%0b expected 0", w_tick[0]);
        end
        cycle("clr_rel");
        n_vec++;
        if (w_tick[0] !== 1'b1 || w_q[0] !== 4'd1) begin
            n_err++;
            $display("FAIL clr_first: got q=%0d tick=%0b expected q=1 tick=1", w_q[0], w_tick[0]);
        end
        en = 1'b0;
        held = w_q[1];
        repeat (10) cycle("freeze");
        n_vec++;
        if (w_q[1] !== held || w_tick !== 3'b000) begin
            n_err++;
            $display("FAIL freeze: got q=%0d tick=%0b expected q=%0d tick=000", w_q[1], w_tick, held);
        end
    endtask

    // Randomised mix of all inputs including loads, freezes and clears
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = c_W'($urandom_range(0, 15));
            mode     = 2'($urandom_range(0, 3));
            dir      = 1'($urandom_range(0, 1));
            step     = c_W'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) pulse_clr("rand_clr");
            cycle("random");
        end
    endtask

    initial begin
        test_reset();
        test_even_up();
        test_odd_down();
        test_mode_switch();
        test_step();
        test_load_terminal();
        test_clr_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_step_mode_counter
`default_nettype wire
